// File: rtl/apb_gpio_arbiter_pkg.sv
// Shared types for the APB GPIO arbiter: FSM state encoding and the APB phase
// decode used to drive Psel/Penable straight from the state register.
package apb_gpio_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_e;

    typedef struct packed {
        logic sel;
        logic enable;
    } apb_phase_t;

    localparam apb_phase_t PHASE_IDLE   = '{sel: 1'b0, enable: 1'b0};
    localparam apb_phase_t PHASE_SETUP  = '{sel: 1'b1, enable: 1'b0};
    localparam apb_phase_t PHASE_ACCESS = '{sel: 1'b1, enable: 1'b1};

    // DONE shares the idle bus phase; the completion pulse is decoded separately.
    function automatic apb_phase_t phaseOf(input state_e s);
        case (s)
            SETUP:   return PHASE_SETUP;
            ACCESS:  return PHASE_ACCESS;
            default: return PHASE_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/apb_gpio_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request searching upward from
// the slot after ptr_i, wrapping modulo NREQ.
module rr_picker #(
    parameter int NREQ = 2,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic            valid_o,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   idx_o
);

    logic          found;
    logic [IW-1:0] pos;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            pos = IW'((int'(ptr_i) + k) % NREQ);
            if (!found && req_i[pos]) begin
                found      = 1'b1;
                gnt_o[pos] = 1'b1;
                idx_o      = pos;
            end
        end
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/apb_gpio_arbiter.sv
// APB requester-side controller sharing one bus to a GPIO slave among NREQ
// local requesters, with round-robin arbitration and an ACCESS-phase timeout.
module apb_gpio_arbiter
    import apb_gpio_arbiter_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int AW      = 8,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [NREQ-1:0]    req_i,
    input  logic [NREQ-1:0]    req_write_i,
    input  logic [NREQ*AW-1:0] req_addr_i,
    input  logic [NREQ*DW-1:0] req_wdata_i,
    output logic [NREQ-1:0]  grant_o,
    output logic [NREQ-1:0]  done_o,
    output logic [DW-1:0]    rdata_o,
    output logic             err_o,
    output logic             Psel_o,
    output logic             Penable_o,
    output logic             Pwrite_o,
    output logic [AW-1:0]    Paddr_o,
    output logic [DW-1:0]    Pwdata_o,
    input  logic [DW-1:0]    Prdata_i,
    input  logic             Pready_i
);

    localparam int IW = $clog2(NREQ);
    localparam int TW = $clog2(TIMEOUT);

    state_e          stateQ, stateD;
    logic [NREQ-1:0] gntQ, gntD;
    logic [IW-1:0]   winQ, winD;
    logic [IW-1:0]   rrPtrQ, rrPtrD;
    logic            pwriteQ, pwriteD;
    logic [AW-1:0]   paddrQ, paddrD;
    logic [DW-1:0]   pwdataQ, pwdataD;
    logic [DW-1:0]   rdataQ, rdataD;
    logic            errQ, errD;
    logic [TW-1:0]   tcntQ, tcntD;

    logic            pickValid;
    logic [NREQ-1:0] pickGnt;
    logic [IW-1:0]   pickIdx;
    apb_phase_t      phase;

    rr_picker #(.NREQ(NREQ), .IW(IW)) uPicker (
        .req_i   (req_i),
        .ptr_i   (rrPtrQ),
        .valid_o (pickValid),
        .gnt_o   (pickGnt),
        .idx_o   (pickIdx)
    );

    // Reset aborts any transfer in flight; no completion is reported for it.
    always_ff @(posedge clock) begin
        if (!reset) begin
            stateQ  <= IDLE;
            gntQ    <= '0;
            winQ    <= '0;
            rrPtrQ  <= IW'(NREQ - 1);
            pwriteQ <= 1'b0;
            paddrQ  <= '0;
            pwdataQ <= '0;
            rdataQ  <= '0;
            errQ    <= 1'b0;
            tcntQ   <= '0;
        end else begin
            stateQ  <= stateD;
            gntQ    <= gntD;
            winQ    <= winD;
            rrPtrQ  <= rrPtrD;
            pwriteQ <= pwriteD;
            paddrQ  <= paddrD;
            pwdataQ <= pwdataD;
            rdataQ  <= rdataD;
            errQ    <= errD;
            tcntQ   <= tcntD;
        end
    end

    // Requests are only sampled in IDLE, so dropping req mid-transfer is harmless.
    always_comb begin
        stateD  = stateQ;
        gntD    = gntQ;
        winD    = winQ;
        rrPtrD  = rrPtrQ;
        pwriteD = pwriteQ;
        paddrD  = paddrQ;
        pwdataD = pwdataQ;
        rdataD  = rdataQ;
        errD    = errQ;
        tcntD   = tcntQ;
        case (stateQ)
            IDLE: begin
                if (pickValid) begin
                    gntD    = pickGnt;
                    winD    = pickIdx;
                    pwriteD = req_write_i[pickIdx];
                    paddrD  = req_addr_i[int'(pickIdx)*AW +: AW];
                    pwdataD = req_wdata_i[int'(pickIdx)*DW +: DW];
                    stateD  = SETUP;
                end
            end
            SETUP: begin
                tcntD  = '0;
                stateD = ACCESS;
            end
            ACCESS: begin
                if (Pready_i) begin
                    if (!pwriteQ) rdataD = Prdata_i;
                    errD   = 1'b0;
                    stateD = DONE;
                end else if (tcntQ == TW'(TIMEOUT - 1)) begin
                    errD   = 1'b1;
                    stateD = DONE;
                end else begin
                    tcntD = tcntQ + TW'(1);
                end
            end
            DONE: begin
                rrPtrD = winQ;
                gntD   = '0;
                stateD = IDLE;
            end
            default: stateD = IDLE;
        endcase
    end

    always_comb begin
        phase  = phaseOf(stateQ);
        done_o = '0;
        if (stateQ == DONE) done_o = gntQ;
    end

    assign Psel_o    = phase.sel;
    assign Penable_o = phase.enable;
    assign grant_o   = gntQ;
    assign rdata_o   = rdataQ;
    assign err_o     = errQ;
    assign Pwrite_o  = pwriteQ;
    assign Paddr_o   = paddrQ;
    assign Pwdata_o  = pwdataQ;

endmodule

// File: tb/tb_apb_gpio_arbiter.sv
// Self-checking bench for apb_gpio_arbiter: directed scenarios plus a randomized
// run checked against a round-robin/slave-latency reference model.
module tb_apb_gpio_arbiter;

    localparam int NREQ    = 2;
    localparam int AW      = 8;
    localparam int DW      = 32;
    localparam int TIMEOUT = 16;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic [NREQ-1:0]    req_i       = '0;
    logic [NREQ-1:0]    req_write_i = '0;
    logic [NREQ*AW-1:0] req_addr_i  = '0;
    logic [NREQ*DW-1:0] req_wdata_i = '0;
    logic [NREQ-1:0]    grant_o, done_o;
    logic [DW-1:0]      rdata_o, Pwdata_o;
    logic               err_o, Psel_o, Penable_o, Pwrite_o;
    logic [AW-1:0]      Paddr_o;
    logic [DW-1:0]      Prdata_i = '0;
    logic               Pready_i;

    int total = 0;
    int bad   = 0;
    int readyDelay = 0;
    int accCnt = 0;
    int modelPtr = NREQ - 1;
    logic [DW-1:0] modelRdata = '0;

    apb_gpio_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_i       (req_i),
        .req_write_i (req_write_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .grant_o     (grant_o),
        .done_o      (done_o),
        .rdata_o     (rdata_o),
        .err_o       (err_o),
        .Psel_o      (Psel_o),
        .Penable_o   (Penable_o),
        .Pwrite_o    (Pwrite_o),
        .Paddr_o     (Paddr_o),
        .Pwdata_o    (Pwdata_o),
        .Prdata_i    (Prdata_i),
        .Pready_i    (Pready_i)
    );

    always #5 clock = ~clock;

    // Slave model: Pready stays low for readyDelay ACCESS cycles, then rises.
    always @(posedge clock) accCnt <= (Psel_o && Penable_o) ? accCnt + 1 : 0;
    assign Pready_i = (accCnt >= readyDelay);

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic setReq(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_write_i[i]          = wr;
        req_addr_i[i*AW +: AW]  = a;
        req_wdata_i[i*DW +: DW] = d;
        req_i[i]                = 1'b1;
    endtask

    task automatic waitDone(input int limit, input logic [AW-1:0] expAddr, input logic expWrite,
                            input logic [DW-1:0] expWdata, output logic got, output int penCnt,
                            output logic busOk);
        int cycles;
        got = 1'b0; cycles = 0; penCnt = 0; busOk = 1'b1;
        while (!got && cycles < limit) begin
            tick();
            cycles++;
            if (done_o != '0) got = 1'b1;
            else begin
                if (Penable_o) penCnt++;
                if (Psel_o && (Paddr_o !== expAddr || Pwrite_o !== expWrite || Pwdata_o !== expWdata))
                    busOk = 1'b0;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b0; req_i = '0;
        tick(); tick();
        total++; if ({Psel_o, Penable_o} !== 2'b00) begin bad++; $display("[TB] FAIL reset_bus: got %b want 00", {Psel_o, Penable_o}); end
        total++; if (grant_o !== '0 || done_o !== '0) begin bad++; $display("[TB] FAIL reset_grant_done: got %b/%b want 0/0", grant_o, done_o); end
        total++; if (err_o !== 1'b0 || Pwrite_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_err_pwrite: got %b/%b want 0/0", err_o, Pwrite_o); end
        total++; if (Paddr_o !== '0 || Pwdata_o !== '0 || rdata_o !== '0) begin bad++; $display("[TB] FAIL reset_data: got %h/%h/%h want 0", Paddr_o, Pwdata_o, rdata_o); end
        reset = 1'b1;
        tick();
        total++; if (Psel_o !== 1'b0) begin bad++; $display("[TB] FAIL idle_no_req: Psel got %b want 0", Psel_o); end
        modelPtr = NREQ - 1; modelRdata = '0;
    endtask

    task automatic test_single_write;
        readyDelay = 0;
        setReq(0, 1'b1, 8'h04, 32'hA5A5A5A5);
        tick();
        total++; if ({Psel_o, Penable_o} !== 2'b10) begin bad++; $display("[TB] FAIL sw_setup: got %b want 10", {Psel_o, Penable_o}); end
        total++; if (grant_o !== 2'b01) begin bad++; $display("[TB] FAIL sw_grant: got %b want 01", grant_o); end
        total++; if (Paddr_o !== 8'h04 || Pwdata_o !== 32'hA5A5A5A5 || Pwrite_o !== 1'b1) begin bad++; $display("[TB] FAIL sw_bus: got %h/%h/%b want 04/a5a5a5a5/1", Paddr_o, Pwdata_o, Pwrite_o); end
        tick();
        total++; if ({Psel_o, Penable_o} !== 2'b11) begin bad++; $display("[TB] FAIL sw_access: got %b want 11", {Psel_o, Penable_o}); end
        tick();
        total++; if (done_o !== 2'b01 || err_o !== 1'b0) begin bad++; $display("[TB] FAIL sw_done: got %b err %b want 01 err 0", done_o, err_o); end
        total++; if (rdata_o !== modelRdata) begin bad++; $display("[TB] FAIL sw_rdata: got %h want %h", rdata_o, modelRdata); end
        req_i = '0;
        tick();
        total++; if (done_o !== '0 || grant_o !== '0) begin bad++; $display("[TB] FAIL sw_after: got %b/%b want 00/00", done_o, grant_o); end
        modelPtr = 0;
    endtask

    task automatic test_slow_read;
        logic got, busOk;
        int pen;
        readyDelay = 5; Prdata_i = 32'h0000_00F0;
        setReq(0, 1'b0, 8'h10, 32'h0);
        waitDone(40, 8'h10, 1'b0, 32'h0, got, pen, busOk);
        total++; if (!got) begin bad++; $display("[TB] FAIL slow_done_seen: got timeout want done"); end
        total++; if (pen !== 6) begin bad++; $display("[TB] FAIL slow_penable_cycles: got %0d want 6", pen); end
        total++; if (!busOk) begin bad++; $display("[TB] FAIL slow_paddr_stable: got unstable want stable"); end
        total++; if (done_o !== 2'b01 || rdata_o !== 32'hF0 || err_o !== 1'b0) begin bad++; $display("[TB] FAIL slow_result: got %b/%h/%b want 01/f0/0", done_o, rdata_o, err_o); end
        req_i = '0;
        tick();
        modelPtr = 0; modelRdata = 32'hF0;
    endtask

    task automatic test_timeout;
        logic got, busOk;
        int pen;
        readyDelay = 1000; Prdata_i = 32'hDEADBEEF;
        setReq(1, 1'b0, 8'h20, 32'h0);
        waitDone(60, 8'h20, 1'b0, 32'h0, got, pen, busOk);
        total++; if (!got) begin bad++; $display("[TB] FAIL to_done_seen: got timeout want done"); end
        total++; if (pen !== TIMEOUT) begin bad++; $display("[TB] FAIL to_access_cycles: got %0d want %0d", pen, TIMEOUT); end
        total++; if (done_o !== 2'b10 || err_o !== 1'b1) begin bad++; $display("[TB] FAIL to_err: got %b err %b want 10 err 1", done_o, err_o); end
        total++; if (rdata_o !== modelRdata) begin bad++; $display("[TB] FAIL to_rdata_kept: got %h want %h", rdata_o, modelRdata); end
        req_i = '0;
        tick();
        modelPtr = 1;
        readyDelay = 0; Prdata_i = 32'h12345678;
        setReq(0, 1'b0, 8'h30, 32'h0);
        waitDone(20, 8'h30, 1'b0, 32'h0, got, pen, busOk);
        total++; if (!got || done_o !== 2'b01 || err_o !== 1'b0 || rdata_o !== 32'h12345678) begin bad++; $display("[TB] FAIL to_recover: got %b/%b/%h want 01/0/12345678", done_o, err_o, rdata_o); end
        req_i = '0;
        tick();
        modelPtr = 0; modelRdata = 32'h12345678;
    endtask

    task automatic test_contention;
        logic [NREQ-1:0] g[8];
        int cyc[8];
        int n;
        logic [NREQ-1:0] expG;
        reset = 1'b0; req_i = '0;
        tick();
        reset = 1'b1;
        modelPtr = NREQ - 1; modelRdata = '0;
        readyDelay = 0;
        setReq(0, 1'b1, 8'h01, 32'h1);
        setReq(1, 1'b1, 8'h02, 32'h2);
        n = 0;
        for (int c = 1; c <= 15; c++) begin
            tick();
            if (Psel_o && !Penable_o && n < 8) begin g[n] = grant_o; cyc[n] = c; n++; end
        end
        req_i = '0;
        total++; if (n !== 4) begin bad++; $display("[TB] FAIL cont_count: got %0d want 4", n); end
        for (int k = 0; k < n && k < 4; k++) begin
            modelPtr = (modelPtr + 1) % NREQ;
            expG = '0; expG[modelPtr] = 1'b1;
            total++; if (g[k] !== expG || cyc[k] !== 1 + 4*k) begin bad++; $display("[TB] FAIL cont_grant%0d: got %b@%0d want %b@%0d", k, g[k], cyc[k], expG, 1 + 4*k); end
        end
        tick(); tick();
        total++; if (Psel_o !== 1'b0) begin bad++; $display("[TB] FAIL cont_stop: Psel got %b want 0", Psel_o); end
    endtask

    task automatic test_reset_mid_access;
        logic got, busOk;
        int pen;
        readyDelay = 1000;
        setReq(0, 1'b1, 8'h40, 32'h1111);
        tick(); tick(); tick();
        total++; if (Penable_o !== 1'b1) begin bad++; $display("[TB] FAIL rst_in_access: Penable got %b want 1", Penable_o); end
        reset = 1'b0;
        tick();
        total++; if ({Psel_o, Penable_o} !== 2'b00 || grant_o !== '0 || done_o !== '0) begin bad++; $display("[TB] FAIL rst_abort: got %b/%b/%b want 00/00/00", {Psel_o, Penable_o}, grant_o, done_o); end
        reset = 1'b1; req_i = '0; readyDelay = 0;
        modelPtr = NREQ - 1; modelRdata = '0;
        setReq(1, 1'b1, 8'h50, 32'h2222);
        tick();
        total++; if (grant_o !== 2'b10 || Psel_o !== 1'b1) begin bad++; $display("[TB] FAIL rst_regrant: got %b/%b want 10/1", grant_o, Psel_o); end
        waitDone(20, 8'h50, 1'b1, 32'h2222, got, pen, busOk);
        total++; if (!got || done_o !== 2'b10 || rdata_o !== modelRdata) begin bad++; $display("[TB] FAIL rst_done: got %b/%h want 10/%h", done_o, rdata_o, modelRdata); end
        req_i = '0;
        tick();
        modelPtr = 1;
    endtask

    task automatic test_req_drop;
        int doneCnt, otherCnt;
        readyDelay = 2;
        setReq(0, 1'b1, 8'h60, 32'h3333);
        tick();
        total++; if (Psel_o !== 1'b1 || grant_o !== 2'b01) begin bad++; $display("[TB] FAIL drop_setup: got %b/%b want 1/01", Psel_o, grant_o); end
        req_i[0] = 1'b0;
        doneCnt = 0; otherCnt = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (done_o[0]) doneCnt++;
            if (done_o[1]) otherCnt++;
        end
        total++; if (doneCnt !== 1 || otherCnt !== 0) begin bad++; $display("[TB] FAIL drop_done_once: got %0d/%0d want 1/0", doneCnt, otherCnt); end
        modelPtr = 0;
    endtask

    task automatic test_random;
        logic [NREQ-1:0] reqVec, expOh;
        logic            wr[NREQ];
        logic [AW-1:0]   ad[NREQ];
        logic [DW-1:0]   wd[NREQ];
        logic            got, busOk, expErr;
        logic [DW-1:0]   expRdata;
        int              pen, expAcc, w;
        reqVec = '0;
        for (int t = 0; t < 40; t++) begin
            while (reqVec == '0) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (!reqVec[i] && $urandom_range(0, 1) == 1) begin
                        reqVec[i] = 1'b1;
                        wr[i] = 1'($urandom_range(0, 1));
                        ad[i] = AW'($urandom);
                        wd[i] = DW'($urandom);
                        setReq(i, wr[i], ad[i], wd[i]);
                    end
                end
            end
            readyDelay = ($urandom_range(0, 7) == 0) ? 100 : int'($urandom_range(0, 3));
            Prdata_i = DW'($urandom);
            w = -1;
            for (int k = 1; k <= NREQ; k++)
                if (w < 0 && reqVec[(modelPtr + k) % NREQ]) w = (modelPtr + k) % NREQ;
            expOh = '0; expOh[w] = 1'b1;
            expErr = (readyDelay >= TIMEOUT);
            expAcc = expErr ? TIMEOUT : readyDelay + 1;
            expRdata = (!expErr && !wr[w]) ? Prdata_i : modelRdata;
            waitDone(60, ad[w], wr[w], wd[w], got, pen, busOk);
            total++; if (!got) begin bad++; $display("[TB] FAIL rnd%0d_done_seen: got timeout want done", t); end
            total++; if (done_o !== expOh || grant_o !== expOh) begin bad++; $display("[TB] FAIL rnd%0d_winner: got %b/%b want %b", t, done_o, grant_o, expOh); end
            total++; if (err_o !== expErr) begin bad++; $display("[TB] FAIL rnd%0d_err: got %b want %b", t, err_o, expErr); end
            total++; if (rdata_o !== expRdata) begin bad++; $display("[TB] FAIL rnd%0d_rdata: got %h want %h", t, rdata_o, expRdata); end
            total++; if (pen !== expAcc) begin bad++; $display("[TB] FAIL rnd%0d_access_cycles: got %0d want %0d", t, pen, expAcc); end
            total++; if (!busOk) begin bad++; $display("[TB] FAIL rnd%0d_bus_stable: got unstable want stable", t); end
            modelPtr = w; modelRdata = expRdata;
            reqVec[w] = 1'b0;
            req_i = reqVec;
        end
        req_i = '0;
        tick(); tick();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_slow_read();
        test_timeout();
        test_contention();
        test_reset_mid_access();
        test_req_drop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
